// File: rtl/stack_mem_master.sv
// stack_mem_master
// Initiator-side controller for the 32x8 data memory of the multi-cycle stack
// processor. Accepts PUSH/POP/LOAD/STORE requests over a valid/ready handshake,
// drives the memory strobes, address and write data, maintains the stack
// pointer and occupancy count, and reports completion with a one-cycle done.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only in IDLE. req_* inputs are ignored in
// every other state.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_op                 00 PUSH, 01 POP, 10 LOAD, 11 STORE
//   req_addr, req_wdata    LOAD/STORE address, PUSH/STORE data
//   done, err, rdata       completion pulse, over/underflow flag, read result
//   sp, count, empty, full stack status
//   mem_read, mem_write    memory strobes (one cycle per access)
//   mem_addr, mem_wdata    memory address and write data
//   mem_rdata              memory read data (combinational from mem_addr)
module stack_mem_master #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int STACK_TOP = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  localparam logic [ADDR_W-1:0] SP_RESET   = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic [1:0]          op_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [ADDR_W:0]     count_q;
  logic                is_empty;
  logic                is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_PUSH;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      sp_q    <= SP_RESET;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            data_q <= req_wdata;
            case (req_op)
              OP_PUSH: begin
                addr_q <= sp_q;
                err_q  <= is_full;
                state  <= is_full ? DONE : WR;
              end
              OP_POP: begin
                // sp points at the next free slot, so the top entry is one above.
                addr_q <= sp_q + 1'b1;
                err_q  <= is_empty;
                state  <= is_empty ? DONE : RD;
              end
              OP_LOAD: begin
                addr_q <= req_addr;
                err_q  <= 1'b0;
                state  <= RD;
              end
              OP_STORE: begin
                addr_q <= req_addr;
                err_q  <= 1'b0;
                state  <= WR;
              end
            endcase
          end
        end
        RD: begin
          rdata_q <= mem_rdata;
          state   <= DONE;
        end
        WR: begin
          state <= DONE;
        end
        DONE: begin
          // Stack bookkeeping commits only once the access has completed.
          if (!err_q) begin
            if (op_q == OP_PUSH) begin
              sp_q    <= sp_q - 1'b1;
              count_q <= count_q + 1'b1;
            end else if (op_q == OP_POP) begin
              sp_q    <= sp_q + 1'b1;
              count_q <= count_q - 1'b1;
            end
          end
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode of the registered state; rst masks the strobes and the
  // completion pulse so a reset landing mid-request never touches memory
  // or reports a dropped request.
  assign req_ready = (state == IDLE);
  assign done      = (state == DONE) && !rst;
  assign err       = done && err_q;
  assign mem_read  = (state == RD) && !rst;
  assign mem_write = (state == WR) && !rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign rdata     = rdata_q;
  assign sp        = sp_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;

endmodule

// File: tb/tb_stack_mem_master.sv
// Bench for stack_mem_master: directed requests, a behavioural 32x8 memory,
// and a negedge monitor that pops expected completions and memory accesses
// from two queues.
module tb_stack_mem_master;

  localparam logic [1:0] PUSH  = 2'b00;
  localparam logic [1:0] POP   = 2'b01;
  localparam logic [1:0] LOAD  = 2'b10;
  localparam logic [1:0] STORE = 2'b11;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       done, err;
  logic [7:0] rdata;
  logic [4:0] sp;
  logic [5:0] count;
  logic       empty, full;
  logic       mem_read, mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  stack_mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata),
    .sp(sp), .count(count), .empty(empty), .full(full),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [32];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0]  exp_q[$];      // {check_rdata, err, rdata}
  logic [13:0] acc_q[$];      // {is_write, addr, wdata}
  int          done_cyc_q[$];
  int          last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    logic [9:0]  e;
    logic [13:0] a;
    if (rst) begin
      check("rst_mem_read", {31'b0, mem_read}, 0);
      check("rst_mem_write", {31'b0, mem_write}, 0);
      check("rst_done", {31'b0, done}, 0);
    end else begin
      if (done) begin
        done_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("done_err", {31'b0, err}, {31'b0, e[8]});
          if (e[9]) check("rdata", {24'b0, rdata}, {24'b0, e[7:0]});
        end
      end
      if (mem_read || mem_write) begin
        check("strobe_excl", {31'b0, mem_read & mem_write}, 0);
        if (acc_q.size() == 0) fail_now("unexpected_access");
        else begin
          a = acc_q.pop_front();
          check("acc_kind", {31'b0, mem_write}, {31'b0, a[13]});
          check("acc_addr", {27'b0, mem_addr}, {27'b0, a[12:8]});
          if (a[13]) check("acc_wdata", {24'b0, mem_wdata}, {24'b0, a[7:0]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic issue(input logic [1:0] op, input logic [4:0] addr,
                       input logic [7:0] wd, input int exp_lat);
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) fail_now("ready_timeout");
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    last_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    if (!done) fail_now("done_timeout");
    else check("latency", cyc - last_acc, exp_lat);
    @(negedge clk);
    check("ready_after_done", {31'b0, req_ready}, 1);
  endtask

  task automatic push_ok(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    acc_q.push_back({1'b1, a, d});
    issue(PUSH, 5'd0, d, 2);
  endtask

  task automatic pop_ok(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, 1'b0, d});
    acc_q.push_back({1'b0, a, 8'h00});
    issue(POP, 5'd0, 8'h00, 2);
  endtask

  task automatic check_status(input string tag, input logic [4:0] e_sp,
                              input logic [5:0] e_cnt, input logic e_empty, input logic e_full);
    check({tag, "_sp"}, {27'b0, sp}, {27'b0, e_sp});
    check({tag, "_count"}, {26'b0, count}, {26'b0, e_cnt});
    check({tag, "_empty"}, {31'b0, empty}, {31'b0, e_empty});
    check({tag, "_full"}, {31'b0, full}, {31'b0, e_full});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  // ---------------- main sequence ----------------
  logic [7:0] b2b_d [4];
  int         b2b_acc [4];

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 1);
    check("reset_rdata", {24'b0, rdata}, 0);
    check("reset_mem_addr", {27'b0, mem_addr}, 0);
    check("reset_mem_wdata", {24'b0, mem_wdata}, 0);
    check("reset_err", {31'b0, err}, 0);
    check_status("reset", 5'd31, 6'd0, 1'b1, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // LIFO basics
    push_ok(5'd31, 8'hA1);
    push_ok(5'd30, 8'hB2);
    push_ok(5'd29, 8'hC3);
    check_status("after_push3", 5'd28, 6'd3, 1'b0, 1'b0);
    pop_ok(5'd29, 8'hC3);
    pop_ok(5'd30, 8'hB2);
    pop_ok(5'd31, 8'hA1);
    check_status("after_pop3", 5'd31, 6'd0, 1'b1, 1'b0);

    // underflow: done the cycle after accept, no access
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    issue(POP, 5'd0, 8'h00, 1);
    check_status("underflow", 5'd31, 6'd0, 1'b1, 1'b0);

    // fill to capacity
    for (int i = 0; i < 32; i++) push_ok(5'(31 - i), 8'(i));
    check_status("filled", 5'd31, 6'd32, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    issue(PUSH, 5'd0, 8'h77, 1);
    check_status("overflow", 5'd31, 6'd32, 1'b0, 1'b1);
    pop_ok(5'd0, 8'h1F);
    check_status("pop_after_full", 5'd0, 6'd31, 1'b0, 1'b0);

    // absolute STORE/LOAD leave the stack alone
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    acc_q.push_back({1'b1, 5'd3, 8'h5A});
    issue(STORE, 5'd3, 8'h5A, 2);
    exp_q.push_back({1'b1, 1'b0, 8'h5A});
    acc_q.push_back({1'b0, 5'd3, 8'h00});
    issue(LOAD, 5'd3, 8'h00, 2);
    check_status("store_load", 5'd0, 6'd31, 1'b0, 1'b0);

    // reset during the RD cycle of a POP: no done, no access expected
    req_valid = 1'b1; req_op = POP;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_ready", {31'b0, req_ready}, 1);
    check("rst_mid_rdata", {24'b0, rdata}, 0);
    check_status("rst_mid", 5'd31, 6'd0, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // back-to-back pushes with req_valid held high
    b2b_d[0] = 8'h11; b2b_d[1] = 8'h22; b2b_d[2] = 8'h33; b2b_d[3] = 8'h44;
    done_cyc_q.delete();
    req_op = PUSH;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (!req_ready && n < 10) begin @(negedge clk); n++; end
      if (!req_ready) fail_now("b2b_ready_timeout");
      req_valid = 1'b1;
      req_wdata = b2b_d[k];
      b2b_acc[k] = cyc;
      exp_q.push_back({1'b0, 1'b0, 8'h00});
      acc_q.push_back({1'b1, 5'(31 - k), b2b_d[k]});
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 1; k < 4; k++) check("b2b_accept_gap", b2b_acc[k] - b2b_acc[k-1], 3);
    check("b2b_done_count", done_cyc_q.size(), 4);
    if (done_cyc_q.size() == 4)
      for (int k = 1; k < 4; k++) check("b2b_done_gap", done_cyc_q[k] - done_cyc_q[k-1], 3);
    check_status("b2b", 5'd27, 6'd4, 1'b0, 1'b0);
    pop_ok(5'd28, 8'h44);
    pop_ok(5'd29, 8'h33);
    pop_ok(5'd30, 8'h22);
    pop_ok(5'd31, 8'h11);
    check_status("b2b_drained", 5'd31, 6'd0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("leftover_done", exp_q.size(), 0);
    check("leftover_access", acc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_mem_master.md
# stack_mem_master

Initiator-side controller for the 32x8 data memory in the multi-cycle stack processor. Accepts push, pop, load and store requests from the control unit over a valid/ready handshake, and drives the memory's read/write strobes, address and write data. Maintains the stack pointer and occupancy count, flags overflow and underflow, and returns read data with a one-cycle done pulse.

## Interface
- ADDR_W, 5, memory address width
- DATA_W, 8, data width
- DEPTH, 32, stack capacity in words; equals 2**ADDR_W
- STACK_TOP, 31, address of the first push; the stack grows downward

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller idle and able to accept
- req_op  in  2  00 PUSH, 01 POP, 10 LOAD, 11 STORE
- req_addr  in  ADDR_W  absolute address for LOAD/STORE; ignored for PUSH/POP
- req_wdata  in  DATA_W  data for PUSH/STORE
- done  out  1  one-cycle pulse; request complete
- err  out  1  valid with done; 1 = overflow (PUSH) or underflow (POP), no memory access made
- rdata  out  DATA_W  result of POP/LOAD; held until the next POP/LOAD completes
- sp  out  ADDR_W  next free slot
- count  out  ADDR_W+1  entries on the stack, 0..DEPTH
- empty, full  out  1  count==0 and count==DEPTH
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory WriteData
- mem_rdata  in  DATA_W  from memory ReadData; combinational from mem_addr while mem_read=1

## Operation
- FSM states: IDLE, RD, WR, DONE. The reset state is IDLE.
- IDLE: req_ready=1. When req_valid=1, latch op, address, data and the error decision:
  - PUSH while full, or POP while empty: go to DONE with err=1.
  - POP/LOAD: go to RD.
  - PUSH/STORE: go to WR.
- Effective address:
  - PUSH: sp
  - POP: sp+1 (modulo 2**ADDR_W)
  - LOAD/STORE: req_addr
- RD: mem_read=1 and mem_addr=effective address. mem_rdata is captured into rdata at the end of the cycle. Go to DONE.
- WR: mem_write=1, mem_addr=effective address, mem_wdata=latched data. Go to DONE.
- DONE: done=1, req_ready=0; err is driven from the latch. Then return to IDLE.
  - On a successful PUSH: sp decrements and count increments, both at the DONE edge.
  - On a successful POP: sp increments and count decrements, both at the DONE edge.
  - LOAD/STORE never change sp or count, even when they address the stack region.
- Strobes are Moore outputs decoded from the registered state. mem_read and mem_write are never high together, and each is high for exactly one cycle per access.
- sp arithmetic wraps modulo 2**ADDR_W. The count guard prevents wrap during normal use.
- req_* inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, done=0, err=0, rdata=0, sp=STACK_TOP, count=0, empty=1, full=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- While rst=1, no strobes are asserted, so the memory's reset-time reload is never disturbed.
- Latency, with the accept edge at cycle 0:
  - Memory access in cycle 1.
  - done in cycle 2.
  - req_ready high again in cycle 3.
  - Throughput is 1 request per 3 cycles.
- Error requests skip the access cycle: done in cycle 1, req_ready high in cycle 2.
- rdata is valid in the done cycle and stays stable afterwards.
- rst asserted mid-operation, in any state: next cycle is IDLE with reset values. The in-flight request is dropped with no done. A write strobe already issued is not undone.

## Test plan
- Reset, then PUSH 0xA1, 0xB2, 0xC3:
  - mem_write at addr 31, 30, 29.
  - Final sp=28, count=3.
  - POP x3 returns 0xC3, 0xB2, 0xA1 with err=0; sp=31, count=0, empty=1.
- POP when empty: done in the cycle after accept, err=1, no mem_read pulse, sp and count unchanged.
- PUSH 32 values 0x00..0x1F:
  - full=1, count=32, sp wrapped to 31.
  - 33rd PUSH gives err=1 with no mem_write.
  - POP returns 0x1F.
- STORE 0x5A to addr 3, then LOAD addr 3: rdata=0x5A, mem_read pulse at addr 3, sp and count unchanged.
- Back-to-back: req_valid held high with 4 PUSHes. Accepts land every 3 cycles, done pulses are exactly 3 cycles apart, and no request is lost or duplicated.
- rst in the RD cycle of a POP: no done, next cycle req_ready=1, sp=31, count=0, rdata=0.
